// File: rtl/cascade_updown_counter.sv
// cascade_updown_counter: presettable binary/BCD up/down counter with cascade carry,
// auto-reload, registered terminal-count pulse and sticky overflow.
module cascade_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  preset_enable,
    input  logic                  up_down,
    input  logic                  bcd,
    input  logic                  carry_in,
    input  logic                  auto_reload,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry_out,
    output logic                  tc_pulse,
    output logic                  overflow
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};
    logic [W-1:0] result_q, result_d, bcd_up, bcd_dn;
    logic         tc_q, tc_d, ov_q, ov_d, term;
    // Digit ripple: invalid codes A-F saturate to 0 (up, with carry) or 9 (down, no borrow).
    always_comb begin
        logic cu, cd;
        logic [3:0] d;
        bcd_up = result_q;
        bcd_dn = result_q;
        cu = 1'b1;
        cd = 1'b1;
        d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = result_q[4*i +: 4];
            bcd_up[4*i +: 4] = !cu ? d : (d >= 4'd9 ? 4'd0 : d + 4'd1);
            bcd_dn[4*i +: 4] = !cd ? d : ((d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1);
            cu = cu && (d >= 4'd9);
            cd = cd && (d == 4'd0);
        end
    end
    always_comb begin
        term = up_down ? (bcd ? result_q == ALL_NINES : &result_q) : result_q == '0;
        tc_d = !preset_enable && !carry_in && term;
        ov_d = !preset_enable && (ov_q || tc_d);
        result_d = preset_enable ? preset :
                   carry_in ? result_q :
                   (term && auto_reload) ? preset :
                   bcd ? (up_down ? bcd_up : bcd_dn) :
                   (up_down ? result_q + W'(1) : result_q - W'(1));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            tc_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            tc_q     <= tc_d;
            ov_q     <= ov_d;
        end
    end
    assign result    = result_q;
    assign carry_out = !(!carry_in && term);
    assign tc_pulse  = tc_q;
    assign overflow  = ov_q;
endmodule

// File: tb/tb_cascade_updown_counter.sv
// tb_cascade_updown_counter: directed self-checking bench for cascade_updown_counter (DIGITS=2).
module tb_cascade_updown_counter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       preset_enable = 1'b0;
    logic       up_down = 1'b1;
    logic       bcd = 1'b0;
    logic       carry_in = 1'b1;
    logic       auto_reload = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] result;
    logic       carry_out, tc_pulse, overflow;
    int         n_checks = 0;
    int         n_fails = 0;
    logic [7:0] div_seq [10] = '{8'h96, 8'h97, 8'h98, 8'h99, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99, 8'h95};
    logic       div_tc  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    cascade_updown_counter #(.DIGITS(2)) dut (
        .clock(clock), .reset(reset), .preset_enable(preset_enable), .up_down(up_down),
        .bcd(bcd), .carry_in(carry_in), .auto_reload(auto_reload), .preset(preset),
        .result(result), .carry_out(carry_out), .tc_pulse(tc_pulse), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        preset = v;
        preset_enable = 1'b1;
        tick();
        preset_enable = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_result", result, 8'h00);
        check("rst_tc", tc_pulse, 1'b0);
        check("rst_ov", overflow, 1'b0);
        check("rst_cout", carry_out, 1'b1);
        #9 reset = 1'b0;
        // binary up across the terminal value
        load(8'hFD);
        check("bin_load", result, 8'hFD);
        carry_in = 1'b0;
        tick();
        check("bin_fe", result, 8'hFE);
        check("bin_fe_tc", tc_pulse, 1'b0);
        tick();
        check("bin_ff", result, 8'hFF);
        check("bin_ff_cout", carry_out, 1'b0);
        check("bin_ff_ov", overflow, 1'b0);
        tick();
        check("bin_00", result, 8'h00);
        check("bin_00_tc", tc_pulse, 1'b1);
        check("bin_00_ov", overflow, 1'b1);
        check("bin_00_cout", carry_out, 1'b1);
        tick();
        check("bin_01", result, 8'h01);
        check("bin_01_tc", tc_pulse, 1'b0);
        check("bin_01_ov", overflow, 1'b1);
        // BCD down through zero
        bcd = 1'b1;
        up_down = 1'b0;
        load(8'h01);
        check("bcd_dn_load", result, 8'h01);
        check("bcd_dn_load_ov", overflow, 1'b0);
        tick();
        check("bcd_dn_00", result, 8'h00);
        check("bcd_dn_00_cout", carry_out, 1'b0);
        tick();
        check("bcd_dn_99", result, 8'h99);
        check("bcd_dn_99_tc", tc_pulse, 1'b1);
        check("bcd_dn_99_ov", overflow, 1'b1);
        tick();
        check("bcd_dn_98", result, 8'h98);
        check("bcd_dn_98_tc", tc_pulse, 1'b0);
        // BCD up divide-by-5 with auto-reload
        up_down = 1'b1;
        auto_reload = 1'b1;
        load(8'h95);
        check("div_load", result, 8'h95);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("div_val%0d", i), result, div_seq[i]);
            check($sformatf("div_tc%0d", i), tc_pulse, div_tc[i]);
        end
        // invalid BCD digits
        auto_reload = 1'b0;
        load(8'h0C);
        tick();
        check("bcd_0c_up", result, 8'h10);
        load(8'h9A);
        check("bcd_9a_cout", carry_out, 1'b1);
        tick();
        check("bcd_9a_up", result, 8'h00);
        check("bcd_9a_tc", tc_pulse, 1'b0);
        check("bcd_9a_ov", overflow, 1'b0);
        // hold, preset clearing overflow, async reset
        load(8'h99);
        tick();
        check("hold_pre", result, 8'h00);
        check("hold_pre_ov", overflow, 1'b1);
        carry_in = 1'b1;
        check("hold_cout", carry_out, 1'b1);
        tick();
        check("hold_val", result, 8'h00);
        check("hold_tc", tc_pulse, 1'b0);
        check("hold_ov", overflow, 1'b1);
        carry_in = 1'b0;
        load(8'h42);
        check("pe_val", result, 8'h42);
        check("pe_ov", overflow, 1'b0);
        tick();
        check("pe_count", result, 8'h43);
        #2 reset = 1'b1;
        #1;
        check("async_rst", result, 8'h00);
        reset = 1'b0;
        tick();
        check("post_rst", result, 8'h01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
